// File: rtl/id_ex_stage.sv
//-----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register for a classic five-stage integer pipeline. Captures
// the decoded instruction into the EX stage, resolving operand hazards by
// forwarding from the EX/MEM and write-back producers. It also flags a
// load-use hazard, which cannot be resolved by forwarding.
//
// Update priority on each rising clk: rst > flush > stall > capture.
//
// Parameters
//   DATA_W  operand / PC / immediate width (default 32)
//   REG_AW  register-index width            (default 5)
//
// Ports
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   id_valid                      decode slot holds a real instruction
//   id_pc, id_imm                 PC and immediate of the decoded instruction
//   id_rs1, id_rs2, id_rd         source / destination register indices
//   id_rd1, id_rd2                register-file read data for rs1 / rs2
//   id_alu_op, id_alu_src         ALU operation and operand-B select
//   id_mem_we, id_mem_re          store / load request
//   id_reg_we                     register write-back enable
//   stall                         hold every ex_* register
//   flush                         insert a bubble (wins over stall)
//   exm_reg_we, exm_rd,
//   exm_result                    EX/MEM producer (highest forwarding priority)
//   wb_reg_we, wb_rd, wb_data     write-back producer (also writes the reg file)
//   ex_*                          registered EX-stage copies of the id_* fields
//   ex_op_a, ex_op_b              forwarded operands
//   load_use_hazard               combinational stall request to fetch/decode
//
// Configuration
//   ID_EX_BUBBLE_CNT_EN           when defined, adds output bubble_cnt[15:0],
//                                 a saturating count of flushed cycles.
//-----------------------------------------------------------------------------
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,

   // Decode stage
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_pc,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [DATA_W-1:0] id_rd1,
   input  logic [DATA_W-1:0] id_rd2,
   input  logic [3:0]        id_alu_op,
   input  logic              id_alu_src,
   input  logic              id_mem_we,
   input  logic              id_mem_re,
   input  logic              id_reg_we,

   // Pipeline control
   input  logic              stall,
   input  logic              flush,

   // Forwarding producers
   input  logic              exm_reg_we,
   input  logic [REG_AW-1:0] exm_rd,
   input  logic [DATA_W-1:0] exm_result,
   input  logic              wb_reg_we,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_data,

   // Execute stage
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_pc,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_AW-1:0] ex_rs1,
   output logic [REG_AW-1:0] ex_rs2,
   output logic [REG_AW-1:0] ex_rd,
   output logic [DATA_W-1:0] ex_op_a,
   output logic [DATA_W-1:0] ex_op_b,
   output logic [3:0]        ex_alu_op,
   output logic              ex_alu_src,
   output logic              ex_mem_we,
   output logic              ex_mem_re,
   output logic              ex_reg_we,

   output logic              load_use_hazard
`ifdef ID_EX_BUBBLE_CNT_EN
   ,
   output logic [15:0]       bubble_cnt
`endif
);

   localparam logic [REG_AW-1:0] REG_ZERO = '0;

   //--------------------------------------------------------------------------
   // Operand forwarding
   //--------------------------------------------------------------------------
   // A producer matches when it writes a non-zero register equal to the source
   // index. x0 is hard-wired to zero in the register file, so it is never
   // forwarded even if a producer claims to write it.
   logic exm_hit_a, exm_hit_b;
   logic wb_hit_a,  wb_hit_b;
   logic [DATA_W-1:0] fwd_a, fwd_b;

   assign exm_hit_a = exm_reg_we && (exm_rd != REG_ZERO) && (exm_rd == id_rs1);
   assign exm_hit_b = exm_reg_we && (exm_rd != REG_ZERO) && (exm_rd == id_rs2);
   assign wb_hit_a  = wb_reg_we  && (wb_rd  != REG_ZERO) && (wb_rd  == id_rs1);
   assign wb_hit_b  = wb_reg_we  && (wb_rd  != REG_ZERO) && (wb_rd  == id_rs2);

   // EX/MEM holds the younger result, so it wins over write-back.
   // NOTE: every combinational output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      fwd_a = id_rd1;
      if (exm_hit_a)
         fwd_a = exm_result;
      else if (wb_hit_a)
         fwd_a = wb_data;

      fwd_b = id_rd2;
      if (exm_hit_b)
         fwd_b = exm_result;
      else if (wb_hit_b)
         fwd_b = wb_data;
   end

   //--------------------------------------------------------------------------
   // Pipeline register
   //--------------------------------------------------------------------------
   // Flush clears everything, not just the control bits, so a bubble is
   // easy to recognise in waveforms. An invalid decode slot still captures
   // its datapath fields, but its side-effect controls are masked to zero.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         ex_valid   <= 1'b0;
         ex_pc      <= '0;
         ex_imm     <= '0;
         ex_rs1     <= '0;
         ex_rs2     <= '0;
         ex_rd      <= '0;
         ex_op_a    <= '0;
         ex_op_b    <= '0;
         ex_alu_op  <= '0;
         ex_alu_src <= 1'b0;
         ex_mem_we  <= 1'b0;
         ex_mem_re  <= 1'b0;
         ex_reg_we  <= 1'b0;
      end else if (!stall) begin
         ex_valid   <= id_valid;
         ex_pc      <= id_pc;
         ex_imm     <= id_imm;
         ex_rs1     <= id_rs1;
         ex_rs2     <= id_rs2;
         ex_rd      <= id_rd;
         ex_op_a    <= fwd_a;
         ex_op_b    <= fwd_b;
         ex_alu_op  <= id_alu_op;
         ex_alu_src <= id_alu_src;
         ex_mem_we  <= id_valid && id_mem_we;
         ex_mem_re  <= id_valid && id_mem_re;
         ex_reg_we  <= id_valid && id_reg_we;
      end
      // stall without flush: every register holds its value
   end

   //--------------------------------------------------------------------------
   // Load-use hazard
   //--------------------------------------------------------------------------
   // A load in EX delivers its data only after MEM, too late to forward into
   // the dependent instruction now in decode. The surrounding control turns
   // this into a fetch/decode stall plus a flush of this stage.
   assign load_use_hazard = ex_valid && ex_mem_re && (ex_rd != REG_ZERO) &&
                            id_valid && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

`ifdef ID_EX_BUBBLE_CNT_EN
   //--------------------------------------------------------------------------
   // Bubble counter: counts flushed cycles, sticks at all-ones.
   //--------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst)
         bubble_cnt <= '0;
      else if (flush && (bubble_cnt != 16'hFFFF))
         bubble_cnt <= bubble_cnt + 16'd1;
   end
`endif

endmodule
